// File: rtl/simon_sequencer.sv
// Simon Says game controller: grows a pseudo-random colour sequence in external memory,
// plays it on the LEDs and checks the player's presses. Optional macro: SIMON_INPUT_TIMEOUT_EN.
module simon_sequencer #(
    parameter int          DEPTH         = 30,
    parameter int          PTR_W         = 5,
    parameter int          DATA_W        = 6,
    parameter int          ON_TICKS      = 4,
    parameter int          OFF_TICKS     = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          TIMEOUT_TICKS = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              btn_valid,
    input  logic [1:0]        btn_color,
    output logic              mem_w_en,
    output logic [PTR_W-1:0]  mem_w_ptr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_r_en,
    output logic [PTR_W-1:0]  mem_r_ptr,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              led_en,
    output logic [1:0]        led_color,
    output logic [PTR_W-1:0]  level,
    output logic              await_input,
    output logic              win,
    output logic              lose
);

    localparam logic [15:0]      SEED    = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_APPEND, S_PLAY_RD, S_PLAY_ON, S_PLAY_OFF,
        S_IN_RD, S_IN_WAIT, S_WIN, S_LOSE
    } state_t;

`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam int PLAY_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_MAX = (TIMEOUT_TICKS > PLAY_MAX) ? TIMEOUT_TICKS : PLAY_MAX;
`else
    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
`endif
    localparam int TICK_W = $clog2(TICK_MAX + 1);

    state_t            state, state_next;
    logic [PTR_W-1:0]  idx;
    logic [15:0]       lfsr;
    logic [1:0]        shown_color, expected_color;
    logic [TICK_W-1:0] tick;
    logic              on_done, off_done, last_step, timed_out;
    logic              unused_ok;

    assign on_done   = (tick == TICK_W'(ON_TICKS - 1));
    assign off_done  = (tick == TICK_W'(OFF_TICKS - 1));
    assign last_step = ((idx + 1'b1) == level);

`ifdef SIMON_INPUT_TIMEOUT_EN
    assign timed_out = (tick == TICK_W'(TIMEOUT_TICKS - 1));
    assign unused_ok = ^mem_r_data[DATA_W-1:2];
`else
    assign timed_out = 1'b0;
    assign unused_ok = ^{mem_r_data[DATA_W-1:2], (TIMEOUT_TICKS != 0)};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_WIN, S_LOSE: if (start) state_next = S_APPEND;
            S_APPEND:   state_next = S_PLAY_RD;
            S_PLAY_RD:  state_next = S_PLAY_ON;
            S_PLAY_ON:  if (on_done) state_next = S_PLAY_OFF;
            S_PLAY_OFF: if (off_done) state_next = last_step ? S_IN_RD : S_PLAY_RD;
            S_IN_RD:    state_next = S_IN_WAIT;
            S_IN_WAIT: begin
                // a press in the timeout's final cycle still takes priority
                if (btn_valid) begin
                    if (btn_color != expected_color) state_next = S_LOSE;
                    else if (!last_step)             state_next = S_IN_RD;
                    else if (level == DEPTH_P)       state_next = S_WIN;
                    else                             state_next = S_APPEND;
                end else if (timed_out) begin
                    state_next = S_LOSE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr           <= SEED;
            level          <= '0;
            idx            <= '0;
            shown_color    <= 2'b00;
            expected_color <= 2'b00;
            tick           <= '0;
        end else begin
            if (state_next != state)          tick <= '0;
            else if (tick != {TICK_W{1'b1}})  tick <= tick + 1'b1;
            case (state)
                S_IDLE, S_WIN, S_LOSE: if (start) level <= '0;
                S_APPEND: begin
                    lfsr  <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                    level <= level + 1'b1;
                    idx   <= '0;
                end
                S_PLAY_RD:  shown_color <= mem_r_data[1:0];
                S_PLAY_OFF: if (off_done) idx <= last_step ? '0 : idx + 1'b1;
                S_IN_RD:    expected_color <= mem_r_data[1:0];
                S_IN_WAIT:  if (btn_valid && (btn_color == expected_color)) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_w_en    = 1'b0;
        mem_w_ptr   = '0;
        mem_w_data  = '0;
        mem_r_en    = 1'b0;
        mem_r_ptr   = '0;
        led_en      = 1'b0;
        led_color   = 2'b00;
        await_input = 1'b0;
        win         = 1'b0;
        lose        = 1'b0;
        case (state)
            S_APPEND: begin
                mem_w_en   = 1'b1;
                mem_w_ptr  = level;
                mem_w_data = {{(DATA_W-2){1'b0}}, lfsr[1:0]};
            end
            S_PLAY_RD, S_IN_RD: begin
                mem_r_en  = 1'b1;
                mem_r_ptr = idx;
            end
            S_PLAY_ON: begin
                led_en    = 1'b1;
                led_color = shown_color;
            end
            S_IN_WAIT: await_input = 1'b1;
            S_WIN:     win = 1'b1;
            S_LOSE:    lose = 1'b1;
            default: ;
        endcase
    end

endmodule
